// File: rtl/qspi_mem_arbiter.sv
// rtl/qspi_mem_arbiter.sv - Quad-SPI bus arbiter and transaction sequencer for fetch (flash) and data (RAM A/B) ports
module qspi_mem_arbiter #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int DUMMY_CYCLES   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fetch_req,
    input  logic [ADDRESS_WIDTH-1:0]  fetch_addr,
    output logic                      fetch_done,
    output logic [DATA_BUS_WIDTH-1:0] fetch_rdata,
    input  logic                      data_req,
    input  logic                      data_we,
    input  logic [ADDRESS_WIDTH-1:0]  data_addr,
    input  logic [DATA_BUS_WIDTH-1:0] data_wdata,
    output logic                      data_done,
    output logic [DATA_BUS_WIDTH-1:0] data_rdata,
    output logic [3:0]                spi_data_out,
    input  logic [3:0]                spi_data_in,
    output logic                      spi_data_oe,
    output logic                      spi_clk_out,
    output logic                      spi_flash_select,
    output logic                      spi_ram_a_select,
    output logic                      spi_ram_b_select
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
    typedef enum logic [1:0] {TGT_FLASH, TGT_RAM_A, TGT_RAM_B} target_t;

    state_t                    state;
    state_t                    next_state;
    target_t                   target;
    logic                      phase;
    logic [7:0]                count;
    logic [7:0]                state_len;
    logic                      last;
    logic                      active;
    logic                      granted_fetch;
    logic                      write_q;
    logic                      prefer_fetch;
    logic                      grant_fetch;
    logic [23:0]               addr_q;
    logic [DATA_BUS_WIDTH-1:0] wdata_q;
    logic [7:0]                cmd_byte;
    logic [3:0]                rx_hi;
    logic [3:0]                addr_nibble;
    logic [ADDRESS_WIDTH-1:0]  data_addr_low;

    // The data port's MSB only selects the RAM; it never goes out on the wire.
    assign data_addr_low = {1'b0, data_addr[ADDRESS_WIDTH-2:0]};
    assign grant_fetch   = fetch_req && (!data_req || prefer_fetch);
    assign active        = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
    assign last          = phase && (count == state_len - 8'd1);
    assign cmd_byte      = granted_fetch ? 8'hEB : (write_q ? 8'h02 : 8'h0B);

    always_comb begin
        state_len = 8'd1;
        case (state)
            CMD:     state_len = 8'd2;
            ADDR:    state_len = 8'd6;
            DUMMY:   state_len = 8'(DUMMY_CYCLES);
            DATA:    state_len = 8'd2;
            default: state_len = 8'd1;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fetch_req || data_req) next_state = CMD;
            CMD:     if (last) next_state = ADDR;
            ADDR:    if (last) next_state = (write_q || DUMMY_CYCLES == 0) ? DATA : DUMMY;
            DUMMY:   if (last) next_state = DATA;
            DATA:    if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            phase         <= 1'b0;
            count         <= 8'd0;
            prefer_fetch  <= 1'b0;
            granted_fetch <= 1'b0;
            write_q       <= 1'b0;
            target        <= TGT_FLASH;
            addr_q        <= 24'd0;
            wdata_q       <= '0;
            rx_hi         <= 4'd0;
            fetch_done    <= 1'b0;
            data_done     <= 1'b0;
            fetch_rdata   <= '0;
            data_rdata    <= '0;
        end else begin
            state      <= next_state;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            if (state == IDLE) begin
                phase <= 1'b0;
                count <= 8'd0;
                if (fetch_req || data_req) begin
                    if (fetch_req && data_req) prefer_fetch <= !prefer_fetch;
                    granted_fetch <= grant_fetch;
                    if (grant_fetch) begin
                        write_q <= 1'b0;
                        addr_q  <= 24'(fetch_addr);
                        target  <= TGT_FLASH;
                    end else begin
                        write_q <= data_we;
                        addr_q  <= 24'(data_addr_low);
                        wdata_q <= data_wdata;
                        target  <= data_addr[ADDRESS_WIDTH-1] ? TGT_RAM_B : TGT_RAM_A;
                    end
                end
            end else if (active) begin
                phase <= !phase;
                if (phase) begin
                    count <= last ? 8'd0 : count + 8'd1;
                    // Read nibbles are captured on the edge that ends the high half of the SPI clock.
                    if (state == DATA) begin
                        if (count == 8'd0) begin
                            rx_hi <= spi_data_in;
                        end else begin
                            if (!write_q && granted_fetch)  fetch_rdata <= {rx_hi, spi_data_in};
                            if (!write_q && !granted_fetch) data_rdata  <= {rx_hi, spi_data_in};
                            fetch_done <= granted_fetch;
                            data_done  <= !granted_fetch;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        case (count[2:0])
            3'd0:    addr_nibble = addr_q[23:20];
            3'd1:    addr_nibble = addr_q[19:16];
            3'd2:    addr_nibble = addr_q[15:12];
            3'd3:    addr_nibble = addr_q[11:8];
            3'd4:    addr_nibble = addr_q[7:4];
            default: addr_nibble = addr_q[3:0];
        endcase
    end

    always_comb begin
        spi_data_out = 4'd0;
        case (state)
            CMD:     spi_data_out = count[0] ? cmd_byte[3:0] : cmd_byte[7:4];
            ADDR:    spi_data_out = addr_nibble;
            DATA:    if (write_q) spi_data_out = count[0] ? wdata_q[3:0] : wdata_q[7:4];
            default: spi_data_out = 4'd0;
        endcase
    end

    assign spi_data_oe      = (state == CMD) || (state == ADDR) || (state == DATA && write_q);
    assign spi_clk_out      = active && phase;
    assign spi_flash_select = !(active && target == TGT_FLASH);
    assign spi_ram_a_select = !(active && target == TGT_RAM_A);
    assign spi_ram_b_select = !(active && target == TGT_RAM_B);
endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// tb/tb_qspi_mem_arbiter.sv - Self-checking bench for qspi_mem_arbiter with SPI device and transaction model
module tb_qspi_mem_arbiter;
    localparam int DC     = 4;
    localparam int RD_LAT = 21 + 2 * DC;
    localparam int WR_LAT = 21;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = 16'd0;
    logic        fetch_done;
    logic [7:0]  fetch_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = 16'd0;
    logic [7:0]  data_wdata = 8'd0;
    logic        data_done;
    logic [7:0]  data_rdata;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_in = 4'd0;
    logic        spi_data_oe;
    logic        spi_clk_out;
    logic        spi_flash_select;
    logic        spi_ram_a_select;
    logic        spi_ram_b_select;

    int n_checks = 0;
    int n_err = 0;

    qspi_mem_arbiter #(.ADDRESS_WIDTH(16), .DATA_BUS_WIDTH(8), .DUMMY_CYCLES(DC)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata),
        .spi_data_out(spi_data_out), .spi_data_in(spi_data_in), .spi_data_oe(spi_data_oe),
        .spi_clk_out(spi_clk_out), .spi_flash_select(spi_flash_select),
        .spi_ram_a_select(spi_ram_a_select), .spi_ram_b_select(spi_ram_b_select)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Device-side memories (updated over SPI) and reference memories (updated by the model).
    logic [7:0] dev_flash [0:65535];
    logic [7:0] dev_ram_a [0:32767];
    logic [7:0] dev_ram_b [0:32767];
    logic [7:0] ref_flash [0:65535];
    logic [7:0] ref_ram_a [0:32767];
    logic [7:0] ref_ram_b [0:32767];

    // SPI device model: counts completed SPI clocks while a select is low.
    int          dev_k = 0;
    int          dev_sel;
    logic [7:0]  dev_cmd = 8'd0;
    logic [23:0] dev_addr = 24'd0;
    logic [7:0]  dev_wbyte = 8'd0;
    logic [7:0]  dev_byte;
    always @(negedge clock) begin
        if (spi_flash_select && spi_ram_a_select && spi_ram_b_select) begin
            dev_k = 0;
        end else begin
            dev_sel = !spi_flash_select ? 0 : (!spi_ram_a_select ? 1 : 2);
            if (spi_clk_out) begin
                if (dev_k < 2) dev_cmd = {dev_cmd[3:0], spi_data_out};
                else if (dev_k < 8) dev_addr = {dev_addr[19:0], spi_data_out};
                else if (dev_cmd == 8'h02 && dev_k < 10) begin
                    dev_wbyte = {dev_wbyte[3:0], spi_data_out};
                    if (dev_k == 9 && dev_sel == 1) dev_ram_a[dev_addr[14:0]] = dev_wbyte;
                    if (dev_k == 9 && dev_sel == 2) dev_ram_b[dev_addr[14:0]] = dev_wbyte;
                end
                dev_k++;
            end else if (dev_cmd != 8'h02 && (dev_k == 8 + DC || dev_k == 9 + DC)) begin
                dev_byte = (dev_sel == 0) ? dev_flash[dev_addr[15:0]] :
                           (dev_sel == 1) ? dev_ram_a[dev_addr[14:0]] : dev_ram_b[dev_addr[14:0]];
                spi_data_in = (dev_k == 8 + DC) ? dev_byte[7:4] : dev_byte[3:0];
            end
        end
    end

    // Transaction-level reference model: grant edge, done cycle, target and nibble stream.
    int          cyc = 0;
    bit          t_valid = 0;
    int          t_g = 0;
    int          t_d = 0;
    bit          t_fetch = 0;
    bit          t_we = 0;
    int          t_tgt = 0;
    logic [7:0]  t_rdata = 8'd0;
    logic [3:0]  t_nib [0:9];
    bit          pref_fetch = 0;
    bit          m_gf;
    logic [23:0] m_a24;
    logic [7:0]  m_cmd;
    logic [7:0]  m_wd;
    logic [7:0]  exp_frd = 8'd0;
    logic [7:0]  exp_drd = 8'd0;

    always @(posedge clock) begin
        if (reset) begin
            t_valid = 0;
            pref_fetch = 0;
            exp_frd = 8'd0;
            exp_drd = 8'd0;
        end else if ((!t_valid || cyc > t_d) && (fetch_req || data_req)) begin
            m_gf = fetch_req && (!data_req || pref_fetch);
            if (fetch_req && data_req) pref_fetch = !pref_fetch;
            t_valid = 1;
            t_g = cyc;
            t_fetch = m_gf;
            if (m_gf) begin
                t_we = 0;
                t_tgt = 0;
                m_a24 = {8'h00, fetch_addr};
                m_cmd = 8'hEB;
                m_wd = 8'd0;
                t_rdata = ref_flash[fetch_addr];
            end else begin
                t_we = data_we;
                t_tgt = data_addr[15] ? 2 : 1;
                m_a24 = {9'h000, data_addr[14:0]};
                m_cmd = data_we ? 8'h02 : 8'h0B;
                m_wd = data_wdata;
                if (data_we && t_tgt == 1) ref_ram_a[data_addr[14:0]] = data_wdata;
                if (data_we && t_tgt == 2) ref_ram_b[data_addr[14:0]] = data_wdata;
                t_rdata = (t_tgt == 2) ? ref_ram_b[data_addr[14:0]] : ref_ram_a[data_addr[14:0]];
            end
            t_d = cyc + (t_we ? WR_LAT : RD_LAT);
            t_nib[0] = m_cmd[7:4];
            t_nib[1] = m_cmd[3:0];
            for (int i = 0; i < 6; i++) t_nib[2 + i] = m_a24[23 - 4 * i -: 4];
            t_nib[8] = m_wd[7:4];
            t_nib[9] = m_wd[3:0];
        end
        cyc++;
    end

    bit c_act;
    bit c_dn;
    int c_o;
    int c_s;
    bit c_clk;
    bit c_oe;
    always @(negedge clock) begin
        c_act = t_valid && cyc > t_g && cyc < t_d;
        c_dn  = t_valid && cyc == t_d;
        if (c_dn && !t_we && t_fetch)  exp_frd = t_rdata;
        if (c_dn && !t_we && !t_fetch) exp_drd = t_rdata;
        chk("fetch_done", 64'(fetch_done), 64'(c_dn && t_fetch));
        chk("data_done", 64'(data_done), 64'(c_dn && !t_fetch));
        chk("fetch_rdata", 64'(fetch_rdata), 64'(exp_frd));
        chk("data_rdata", 64'(data_rdata), 64'(exp_drd));
        chk("flash_cs", 64'(spi_flash_select), 64'(!(c_act && t_tgt == 0)));
        chk("ram_a_cs", 64'(spi_ram_a_select), 64'(!(c_act && t_tgt == 1)));
        chk("ram_b_cs", 64'(spi_ram_b_select), 64'(!(c_act && t_tgt == 2)));
        c_clk = 0;
        c_oe = 0;
        c_s = 0;
        if (c_act) begin
            c_o = cyc - t_g - 1;
            c_s = c_o / 2;
            c_clk = (c_o % 2) == 1;
            c_oe = t_we || c_s < 8;
        end
        chk("spi_clk", 64'(spi_clk_out), 64'(c_clk));
        chk("spi_oe", 64'(spi_data_oe), 64'(c_oe));
        if (c_act && c_oe) chk("spi_nibble", 64'(spi_data_out), 64'(t_nib[c_s]));
    end

    // Random requesters: hold until done, then maybe re-request; occasionally withdraw.
    bit rand_on = 0;
    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 3) != 0) a = a & 16'h801F;
        return a;
    endfunction

    always @(negedge clock) begin
        if (rand_on) begin
            if (fetch_done || !fetch_req) begin
                fetch_req = ($urandom_range(0, 2) == 0);
                fetch_addr = rnd_addr();
            end else if ($urandom_range(0, 60) == 0) begin
                fetch_req = 1'b0;
            end
            if (data_done || !data_req) begin
                data_req = ($urandom_range(0, 2) == 0);
                data_we = 1'($urandom);
                data_addr = rnd_addr();
                data_wdata = 8'($urandom);
            end else if ($urandom_range(0, 60) == 0) begin
                data_req = 1'b0;
            end
        end
    end

    task automatic run_txn(input bit is_fetch, input bit we, input logic [15:0] addr, input logic [7:0] wd,
                           input int drop_at, output int lat, output logic [7:0] rd,
                           output logic [39:0] nibs, output logic [63:0] oe_trace);
        lat = -1;
        rd = 8'd0;
        nibs = 40'd0;
        oe_trace = 64'd0;
        @(negedge clock);
        if (is_fetch) begin
            fetch_req = 1'b1;
            fetch_addr = addr;
        end else begin
            data_req = 1'b1;
            data_we = we;
            data_addr = addr;
            data_wdata = wd;
        end
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == drop_at) begin
                fetch_req = 1'b0;
                data_req = 1'b0;
            end
            oe_trace[i] = spi_data_oe;
            if (spi_clk_out && spi_data_oe) nibs = {nibs[35:0], spi_data_out};
            if ((is_fetch && fetch_done) || (!is_fetch && data_done)) begin
                lat = i;
                rd = is_fetch ? fetch_rdata : data_rdata;
                break;
            end
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        if (lat < 0) chk("txn_timeout", 64'd0, 64'd1);
    endtask

    int          lat;
    logic [7:0]  rd;
    logic [39:0] nibs;
    logic [63:0] oe_tr;
    int          ord_t [0:3];
    bit          ord_f [0:3];
    int          n_ord;
    int          n_fd;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_flash[i] = 8'(i * 7 + 3);
            ref_flash[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 32768; i++) begin
            dev_ram_a[i] = 8'(i ^ 16'h5A);
            ref_ram_a[i] = 8'(i ^ 16'h5A);
            dev_ram_b[i] = 8'(i + 16'h33);
            ref_ram_b[i] = 8'(i + 16'h33);
        end
        dev_flash[16'h0012] = 8'hA5;
        ref_flash[16'h0012] = 8'hA5;
        dev_flash[16'h0040] = 8'h3C;
        ref_flash[16'h0040] = 8'h3C;

        repeat (3) @(negedge clock);
        chk("reset_selects", 64'({spi_flash_select, spi_ram_a_select, spi_ram_b_select}), 64'h7);
        chk("reset_bus", 64'({spi_clk_out, spi_data_oe, spi_data_out, fetch_done, data_done}), 64'h0);
        reset = 1'b0;

        run_txn(1, 0, 16'h0012, 8'h00, 0, lat, rd, nibs, oe_tr);
        chk("fetch_lat", 64'(lat), 64'd29);
        chk("fetch_byte", 64'(rd), 64'hA5);
        chk("fetch_nibbles", 64'(nibs[31:0]), 64'hEB000012);

        run_txn(0, 1, 16'h8034, 8'h5C, 0, lat, rd, nibs, oe_tr);
        chk("write_lat", 64'(lat), 64'd21);
        chk("write_nibbles", 64'(nibs), 64'h020000345C);
        chk("write_oe", 64'(oe_tr[20:1]), 64'hFFFFF);

        run_txn(0, 0, 16'h8034, 8'h00, 0, lat, rd, nibs, oe_tr);
        chk("readback_lat", 64'(lat), 64'd29);
        chk("readback_byte", 64'(rd), 64'h5C);

        run_txn(0, 0, 16'h0100, 8'h00, 0, lat, rd, nibs, oe_tr);
        chk("ram_a_lat", 64'(lat), 64'd29);
        chk("ram_a_nibbles", 64'(nibs[31:0]), 64'h0B000100);
        chk("oe_last_addr", 64'(oe_tr[16]), 64'd1);
        chk("oe_first_dummy", 64'(oe_tr[17]), 64'd0);

        // Both raised together after reset and held: data, fetch, data, fetch.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 16'h0012;
        data_req = 1'b1;
        data_we = 1'b0;
        data_addr = 16'h0100;
        n_ord = 0;
        for (int i = 1; i <= 200 && n_ord < 4; i++) begin
            @(negedge clock);
            if (data_done || fetch_done) begin
                ord_t[n_ord] = i;
                ord_f[n_ord] = fetch_done;
                n_ord++;
            end
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        chk("rr_count", 64'(n_ord), 64'd4);
        chk("rr_order", 64'({ord_f[0], ord_f[1], ord_f[2], ord_f[3]}), 64'b0101);
        chk("rr_times", 64'({8'(ord_t[0]), 8'(ord_t[1]), 8'(ord_t[2]), 8'(ord_t[3])}),
            64'({8'd29, 8'd59, 8'd89, 8'd119}));

        // Reset during ADDR of a fetch.
        @(negedge clock);
        fetch_req = 1'b1;
        fetch_addr = 16'h0012;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        fetch_req = 1'b0;
        @(negedge clock);
        chk("abort_selects", 64'({spi_flash_select, spi_ram_a_select, spi_ram_b_select}), 64'h7);
        chk("abort_clk_oe", 64'({spi_clk_out, spi_data_oe}), 64'h0);
        reset = 1'b0;
        n_fd = 0;
        repeat (40) begin
            @(negedge clock);
            if (fetch_done) n_fd++;
        end
        chk("abort_no_done", 64'(n_fd), 64'd0);
        run_txn(1, 0, 16'h0012, 8'h00, 0, lat, rd, nibs, oe_tr);
        chk("after_abort_lat", 64'(lat), 64'd29);
        chk("after_abort_byte", 64'(rd), 64'hA5);

        // Request withdrawn during DUMMY still completes.
        run_txn(1, 0, 16'h0040, 8'h00, 20, lat, rd, nibs, oe_tr);
        chk("drop_lat", 64'(lat), 64'd29);
        chk("drop_byte", 64'(rd), 64'h3C);

        rand_on = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 500) == 0);
        end
        rand_on = 0;
        reset = 1'b0;
        fetch_req = 1'b0;
        data_req = 1'b0;
        repeat (40) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
